// File: rtl/tm1638_responder.sv
// tm1638_responder
//   Responder end of the TM1638 3-wire link (STB/CLK/DIO). Decodes host
//   commands, holds the 16-byte display RAM and display-control state, and
//   shifts four key-scan bytes back to the host on read commands.
//
// Ports
//   clkIn       system clock (tm_clk is asynchronous to it)
//   rst_n       asynchronous active-low reset
//   tm_cs       host chip select, active low
//   tm_clk      host serial clock, idles high
//   tm_dio_in   DIO pad input
//   tm_dio_out  DIO pad output value
//   tm_dio_oe   DIO pad output enable
//   keys_in     key-scan image, read byte n = keys_in[8n+7:8n]
//   ram_addr    display RAM read address
//   ram_data    display RAM[ram_addr], combinational
//   disp_on     display enable from last display-control command
//   brightness  pulse width from last display-control command
//   cmd_valid   one-cycle pulse per decoded command byte
//   cmd_byte    last decoded command byte
//   proto_err   one-cycle pulse on unknown command or misplaced data byte
module tm1638_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clkIn,
   input  logic        rst_n,
   input  logic        tm_cs,
   input  logic        tm_clk,
   input  logic        tm_dio_in,
   output logic        tm_dio_out,
   output logic        tm_dio_oe,
   input  logic [31:0] keys_in,
   input  logic [3:0]  ram_addr,
   output logic [7:0]  ram_data,
   output logic        disp_on,
   output logic [2:0]  brightness,
   output logic        cmd_valid,
   output logic [7:0]  cmd_byte,
   output logic        proto_err
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_WDATA  = 3'd2;
   localparam logic [2:0] ST_READ   = 3'd3;
   localparam logic [2:0] ST_IGNORE = 3'd4;

   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] dio_sync;
   logic                   cs_s, sclk_s, dio_s;
   logic                   cs_prev_reg, sclk_prev_reg;
   logic                   cs_fall, sclk_rise, sclk_fall;
   logic                   shifting, byte_done, ram_we;
   logic [7:0]             rx_byte;

   logic [2:0]  state_reg;
   logic [2:0]  bit_cnt_reg;
   logic [6:0]  shift_reg;
   logic [3:0]  addr_reg;
   logic        fixed_addr_reg;
   logic [31:0] snap_reg;
   logic [7:0]  ram [16];

   // The chip-select chain resets low so that a host already holding
   // tm_cs low when reset is released never produces a falling edge;
   // traffic is only accepted after tm_cs has been seen high.
   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync       <= '0;
         sclk_sync     <= '1;
         dio_sync      <= '0;
         cs_prev_reg   <= 1'b0;
         sclk_prev_reg <= 1'b1;
      end else begin
         cs_sync       <= {cs_sync[SYNC_STAGES-2:0], tm_cs};
         sclk_sync     <= {sclk_sync[SYNC_STAGES-2:0], tm_clk};
         dio_sync      <= {dio_sync[SYNC_STAGES-2:0], tm_dio_in};
         cs_prev_reg   <= cs_s;
         sclk_prev_reg <= sclk_s;
      end
   end

   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign dio_s     = dio_sync[SYNC_STAGES-1];
   assign cs_fall   = cs_prev_reg & ~cs_s;
   assign sclk_rise = ~sclk_prev_reg & sclk_s;
   assign sclk_fall = sclk_prev_reg & ~sclk_s;

   // Host bits are only collected while selected and not reading; a
   // deselect in the same cycle as a clock edge discards the edge.
   assign shifting  = ~cs_s & ~cs_fall & sclk_rise &
                      ((state_reg == ST_CMD) || (state_reg == ST_WDATA) ||
                       (state_reg == ST_IGNORE));
   assign byte_done = shifting & (bit_cnt_reg == 3'd7);
   assign rx_byte   = {dio_s, shift_reg};
   assign ram_we    = byte_done & (state_reg == ST_WDATA);
   assign ram_data  = ram[ram_addr];

   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      end else if (ram_we) begin
         ram[addr_reg] <= rx_byte;
      end
   end

   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         bit_cnt_reg    <= 3'd0;
         shift_reg      <= 7'd0;
         addr_reg       <= 4'd0;
         fixed_addr_reg <= 1'b0;
         snap_reg       <= 32'd0;
         disp_on        <= 1'b0;
         brightness     <= 3'd0;
         cmd_valid      <= 1'b0;
         cmd_byte       <= 8'h00;
         proto_err      <= 1'b0;
         tm_dio_out     <= 1'b1;
         tm_dio_oe      <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         proto_err <= 1'b0;
         if (cs_s) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 3'd0;
            tm_dio_oe   <= 1'b0;
            tm_dio_out  <= 1'b1;
         end else if (cs_fall) begin
            state_reg   <= ST_CMD;
            bit_cnt_reg <= 3'd0;
         end else if (state_reg == ST_READ) begin
            // Snapshot drains LSB first; zeros shift in behind it so the
            // line reads 0 once all 32 key bits have gone out.
            if (sclk_fall) begin
               tm_dio_out <= snap_reg[0];
               snap_reg   <= {1'b0, snap_reg[31:1]};
            end
         end else if (shifting) begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            shift_reg   <= {dio_s, shift_reg[6:1]};
            if (byte_done) begin
               case (state_reg)
                  ST_CMD: begin
                     cmd_valid <= 1'b1;
                     cmd_byte  <= rx_byte;
                     case (rx_byte[7:6])
                        2'b01: begin
                           fixed_addr_reg <= rx_byte[2];
                           if (rx_byte[1]) begin
                              snap_reg  <= keys_in;
                              tm_dio_oe <= 1'b1;
                              state_reg <= ST_READ;
                           end else begin
                              state_reg <= ST_IGNORE;
                           end
                        end
                        2'b11: begin
                           addr_reg  <= rx_byte[3:0];
                           state_reg <= ST_WDATA;
                        end
                        2'b10: begin
                           disp_on    <= rx_byte[3];
                           brightness <= rx_byte[2:0];
                           state_reg  <= ST_IGNORE;
                        end
                        default: begin
                           proto_err <= 1'b1;
                           state_reg <= ST_IGNORE;
                        end
                     endcase
                  end
                  ST_WDATA: begin
                     if (!fixed_addr_reg) addr_reg <= addr_reg + 4'd1;
                  end
                  default: begin
                     proto_err <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule
